// File: rtl/dispense_scheduler.sv
// dispense_scheduler
//   Serialises dispense requests for two pill dispensers so that only one
//   actuator is driven at a time. Requests come from the slot pulses
//   (masked by each dispenser's schedule) and from override rising edges.
//   Pending requests are served round-robin. Each dispense has a fixed
//   on-time followed by a fixed idle gap, both counted in sec_tick pulses.
//
//   Ports
//     CLOCK_50                       system clock (rising edge)
//     resetn                         async active-low reset
//     sec_tick                       one-cycle pulse per second
//     morningP/afternoonP/eveningP   one-cycle slot pulses
//     sched1, sched2 [2:0]           slot enables: [0] morning, [1] afternoon, [2] evening
//     ov1, ov2                       override levels (rising edge = request)
//     motor1, motor2                 actuator drives, mutually exclusive
//     alarm_en                       high in ARM and ON
//     busy                           high whenever not IDLE
//     pend [1:0]                     pending flags, [0] dispenser 1, [1] dispenser 2
//     drop_cnt [3:0]                 saturating count of lost requests
//
//   state | meaning
//   IDLE  | nothing in service, grant taken when any pend bit is set
//   ARM   | grant latched, waiting for the next sec_tick to start the motor
//   ON    | motor[gnt] driven, counting ON_SECS ticks
//   GAP   | motor off, counting GAP_SECS ticks before the next grant
module dispense_scheduler #(
  parameter int unsigned ON_SECS  = 3,
  parameter int unsigned GAP_SECS = 2
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       sec_tick,
  input  logic       morningP,
  input  logic       afternoonP,
  input  logic       eveningP,
  input  logic [2:0] sched1,
  input  logic [2:0] sched2,
  input  logic       ov1,
  input  logic       ov2,
  output logic       motor1,
  output logic       motor2,
  output logic       alarm_en,
  output logic       busy,
  output logic [1:0] pend,
  output logic [3:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, ARM, ON, GAP} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       gnt;        // 0 = dispenser 1, 1 = dispenser 2
  logic       last;       // last dispenser served, same encoding as gnt
  logic       ov_prev1;
  logic       ov_prev2;

  logic       req1;
  logic       req2;
  logic [1:0] req;
  logic [1:0] clr;
  logic [1:0] drop;
  logic [4:0] drop_sum;
  logic       grant_next;

  always_comb begin
    req1 = (morningP & sched1[0]) | (afternoonP & sched1[1]) |
           (eveningP & sched1[2]) | (ov1 & ~ov_prev1);
    req2 = (morningP & sched2[0]) | (afternoonP & sched2[1]) |
           (eveningP & sched2[2]) | (ov2 & ~ov_prev2);
    req  = {req2, req1};

    // pend[gnt] is released on the ARM->ON transition
    clr = 2'b00;
    if (state == ARM && sec_tick)
      clr = gnt ? 2'b10 : 2'b01;

    // a request only counts as lost if its flag is set and stays set
    drop     = req & pend & ~clr;
    drop_sum = {1'b0, drop_cnt} + {4'b0000, drop[0]} + {4'b0000, drop[1]};

    case (pend)
      2'b01:   grant_next = 1'b0;
      2'b10:   grant_next = 1'b1;
      default: grant_next = ~last;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ov_prev1 <= 1'b0;
      ov_prev2 <= 1'b0;
      pend     <= 2'b00;
      drop_cnt <= 4'd0;
    end else begin
      ov_prev1 <= ov1;
      ov_prev2 <= ov2;
      // set wins over clear
      pend     <= req | (pend & ~clr);
      drop_cnt <= (drop_sum > 5'd15) ? 4'd15 : drop_sum[3:0];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      gnt      <= 1'b0;
      last     <= 1'b1;
      motor1   <= 1'b0;
      motor2   <= 1'b0;
      alarm_en <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // a tick in this cycle is deliberately ignored; ARM waits for the next
          if (pend != 2'b00) begin
            gnt      <= grant_next;
            state    <= ARM;
            alarm_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ARM: begin
          if (sec_tick) begin
            state  <= ON;
            cnt    <= 4'(ON_SECS);
            motor1 <= ~gnt;
            motor2 <= gnt;
            last   <= gnt;
          end
        end
        ON: begin
          if (sec_tick) begin
            if (cnt == 4'd1) begin
              state    <= GAP;
              cnt      <= 4'(GAP_SECS);
              motor1   <= 1'b0;
              motor2   <= 1'b0;
              alarm_en <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        GAP: begin
          if (sec_tick) begin
            if (cnt == 4'd1) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          motor1   <= 1'b0;
          motor2   <= 1'b0;
          alarm_en <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dispense_scheduler.sv
module tb_dispense_scheduler;

  logic       CLOCK_50;
  logic       resetn;
  logic       sec_tick;
  logic       morningP;
  logic       afternoonP;
  logic       eveningP;
  logic [2:0] sched1;
  logic [2:0] sched2;
  logic       ov1;
  logic       ov2;
  logic       motor1;
  logic       motor2;
  logic       alarm_en;
  logic       busy;
  logic [1:0] pend;
  logic [3:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  dispense_scheduler #(.ON_SECS(3), .GAP_SECS(2)) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .sec_tick  (sec_tick),
    .morningP  (morningP),
    .afternoonP(afternoonP),
    .eveningP  (eveningP),
    .sched1    (sched1),
    .sched2    (sched2),
    .ov1       (ov1),
    .ov2       (ov2),
    .motor1    (motor1),
    .motor2    (motor2),
    .alarm_en  (alarm_en),
    .busy      (busy),
    .pend      (pend),
    .drop_cnt  (drop_cnt)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // the two actuators must never be driven together
  always @(negedge CLOCK_50) begin
    if (resetn === 1'b1) begin
      checks++;
      if ((motor1 & motor2) !== 1'b0) begin
        errors++;
        $display("FAIL motor_exclusive: motor1=%b motor2=%b required not both 1", motor1, motor2);
      end
    end
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic slot(input logic m, input logic a, input logic e);
    morningP = m; afternoonP = a; eveningP = e;
    step();
    morningP = 1'b0; afternoonP = 1'b0; eveningP = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    #3 resetn = 1'b0;
    step();
    step();
    checks++;
    if ({motor1, motor2, alarm_en, busy, pend, drop_cnt} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got m1=%b m2=%b al=%b busy=%b pend=%b drop=%0d required all 0",
               motor1, motor2, alarm_en, busy, pend, drop_cnt);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [3:0] exp_m1;
    do_reset();
    sched1 = 3'b001; sched2 = 3'b000;
    slot(1, 0, 0);
    checks++;
    if (pend !== 2'b01) begin errors++; $display("FAIL single_pend: got %b required 01", pend); end
    step();
    checks++;
    if ({busy, alarm_en, motor1} !== 3'b110) begin
      errors++; $display("FAIL single_arm: busy/alarm/motor1 got %b required 110", {busy, alarm_en, motor1});
    end
    tick();
    checks++;
    if (motor1 !== 1'b1 || pend !== 2'b00) begin
      errors++; $display("FAIL single_on: motor1=%b pend=%b required 1 00", motor1, pend);
    end
    exp_m1 = 4'b0011; // motor1 after ticks 1..3 of ON (bit i = tick i+1)
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (motor1 !== exp_m1[i] || motor2 !== 1'b0) begin
        errors++; $display("FAIL single_on_tick%0d: motor1=%b motor2=%b required %b 0", i, motor1, motor2, exp_m1[i]);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b1 || alarm_en !== 1'b0) begin
      errors++; $display("FAIL single_gap: busy=%b alarm=%b required 1 0", busy, alarm_en);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || motor2 !== 1'b0) begin
      errors++; $display("FAIL single_idle: busy=%b motor2=%b required 0 0", busy, motor2);
    end
  endtask

  task automatic test_tie();
    do_reset();
    sched1 = 3'b010; sched2 = 3'b010;
    slot(0, 1, 0);
    checks++;
    if (pend !== 2'b11) begin errors++; $display("FAIL tie_pend: got %b required 11", pend); end
    step();
    tick();
    checks++;
    if (motor1 !== 1'b1 || motor2 !== 1'b0 || pend !== 2'b10) begin
      errors++; $display("FAIL tie_first_d1: m1=%b m2=%b pend=%b required 1 0 10", motor1, motor2, pend);
    end
    repeat (3) tick();
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || motor2 !== 1'b0) begin
      errors++; $display("FAIL tie_gap_end: busy=%b m2=%b required 0 0", busy, motor2);
    end
    step();
    checks++;
    if (busy !== 1'b1 || motor2 !== 1'b0) begin
      errors++; $display("FAIL tie_arm_d2: busy=%b m2=%b required 1 0", busy, motor2);
    end
    tick();
    checks++;
    if (motor2 !== 1'b1 || motor1 !== 1'b0 || pend !== 2'b00) begin
      errors++; $display("FAIL tie_second_d2: m1=%b m2=%b pend=%b required 0 1 00", motor1, motor2, pend);
    end
    repeat (5) tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    sched1 = 3'b001; sched2 = 3'b000;
    slot(1, 0, 0);
    step();
    repeat (6) tick();
    sched1 = 3'b100; sched2 = 3'b100;
    slot(0, 0, 1);
    checks++;
    if (pend !== 2'b11 || busy !== 1'b0) begin
      errors++; $display("FAIL rr_pend: pend=%b busy=%b required 11 0", pend, busy);
    end
    step();
    tick();
    checks++;
    if (motor2 !== 1'b1 || motor1 !== 1'b0 || pend !== 2'b01) begin
      errors++; $display("FAIL rr_grant_d2: m1=%b m2=%b pend=%b required 0 1 01", motor1, motor2, pend);
    end
  endtask

  task automatic test_drops();
    do_reset();
    sched1 = 3'b001; sched2 = 3'b000;
    repeat (3) slot(1, 0, 0);
    checks++;
    if (pend !== 2'b01 || drop_cnt !== 4'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL drop_two: pend=%b drop=%0d busy=%b required 01 2 1", pend, drop_cnt, busy);
    end
    // request coinciding with the ARM->ON clear is kept, not dropped
    morningP = 1'b1; sec_tick = 1'b1;
    step();
    morningP = 1'b0; sec_tick = 1'b0;
    checks++;
    if (pend !== 2'b01 || drop_cnt !== 4'd2 || motor1 !== 1'b1) begin
      errors++; $display("FAIL drop_set_wins: pend=%b drop=%0d m1=%b required 01 2 1", pend, drop_cnt, motor1);
    end
    repeat (12) slot(1, 0, 0);
    checks++;
    if (drop_cnt !== 4'd14) begin errors++; $display("FAIL drop_fourteen: got %0d required 14", drop_cnt); end
    repeat (8) slot(1, 0, 0);
    checks++;
    if (drop_cnt !== 4'd15) begin errors++; $display("FAIL drop_saturate: got %0d required 15", drop_cnt); end
    // two drops in one cycle
    do_reset();
    sched1 = 3'b001; sched2 = 3'b001;
    slot(1, 0, 0);
    slot(1, 0, 0);
    checks++;
    if (pend !== 2'b11 || drop_cnt !== 4'd2) begin
      errors++; $display("FAIL drop_double: pend=%b drop=%0d required 11 2", pend, drop_cnt);
    end
  endtask

  task automatic test_override_on();
    do_reset();
    sched1 = 3'b001; sched2 = 3'b000;
    slot(1, 0, 0);
    step();
    tick();
    ov1 = 1'b1;
    step();
    checks++;
    if (pend !== 2'b01 || motor1 !== 1'b1) begin
      errors++; $display("FAIL ov_queue: pend=%b m1=%b required 01 1", pend, motor1);
    end
    step();
    checks++;
    if (drop_cnt !== 4'd0) begin errors++; $display("FAIL ov_level_no_drop: got %0d required 0", drop_cnt); end
    ov1 = 1'b0;
    repeat (3) tick();
    repeat (2) tick();
    step();
    checks++;
    if (busy !== 1'b1 || motor1 !== 1'b0 || pend !== 2'b01) begin
      errors++; $display("FAIL ov_rearm: busy=%b m1=%b pend=%b required 1 0 01", busy, motor1, pend);
    end
    tick();
    checks++;
    if (motor1 !== 1'b1 || pend !== 2'b00) begin
      errors++; $display("FAIL ov_second_on: m1=%b pend=%b required 1 00", motor1, pend);
    end
    slot(1, 0, 0);
    slot(1, 0, 0);
    resetn = 1'b0;
    #1;
    checks++;
    if ({motor1, busy, alarm_en, pend, drop_cnt} !== 9'b0) begin
      errors++; $display("FAIL reset_mid_on: m1=%b busy=%b al=%b pend=%b drop=%0d required all 0",
                         motor1, busy, alarm_en, pend, drop_cnt);
    end
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_ov_hold();
    sched1 = 3'b000; sched2 = 3'b000;
    resetn = 1'b0;
    ov2 = 1'b1;
    step();
    resetn = 1'b1;
    step();
    checks++;
    if (pend !== 2'b10) begin errors++; $display("FAIL ovhold_req: pend=%b required 10", pend); end
    step();
    tick();
    checks++;
    if (motor2 !== 1'b1 || motor1 !== 1'b0) begin
      errors++; $display("FAIL ovhold_on: m1=%b m2=%b required 0 1", motor1, motor2);
    end
    repeat (5) tick();
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || pend !== 2'b00) begin
      errors++; $display("FAIL ovhold_once: busy=%b pend=%b required 0 00", busy, pend);
    end
    ov2 = 1'b0;
    step();
    ov2 = 1'b1;
    step();
    checks++;
    if (pend !== 2'b10) begin errors++; $display("FAIL ovhold_reedge: pend=%b required 10", pend); end
    ov2 = 1'b0;
  endtask

  initial begin
    resetn = 1'b1; sec_tick = 1'b0;
    morningP = 1'b0; afternoonP = 1'b0; eveningP = 1'b0;
    sched1 = 3'b000; sched2 = 3'b000;
    ov1 = 1'b0; ov2 = 1'b0;
    test_reset();
    test_single();
    test_tie();
    test_round_robin();
    test_drops();
    test_override_on();
    test_ov_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
